// File: rtl/pc_redirect.sv
// Fetch-PC generator with branch/delay-slot and exception redirect handling.
// Optional macro PC_ALIGN_CHECK_EN enables the fetch address-error flag pc_adel.
module pc_redirect #(
    parameter logic [31:0] RESET_PC    = 32'hBFC00000,
    parameter int          FETCH_BYTES = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        id_branch_taken,
    input  logic [31:0] id_branch_target,
    input  logic        id_ds_fetched,
    input  logic        exc_valid,
    input  logic [31:0] exc_target,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic        flush_if,
    output logic        redirect_pending,
    output logic        pc_adel,
    output logic [1:0]  state_dbg,
    output logic [31:0] tgt_dbg
);

    // Handshake: if_pc is offered every cycle; the fetch is accepted when
    // if_ready is high at a rising edge, and only then may if_pc advance
    // (exc_valid is the sole redirect that does not wait for if_ready).

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        WAIT_DS = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [31:0] FB = 32'(FETCH_BYTES);

    state_t      state_q;
    logic [31:0] tgt_q;
    logic [31:0] seq_pc;
    logic        branch_now;

    // Align down to the fetch block, then step one block (wraps mod 2^32).
    assign seq_pc     = (if_pc & ~(FB - 32'd1)) + FB;
    assign branch_now = (state_q == NORMAL) && id_branch_taken;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            if_pc   <= RESET_PC;
            tgt_q   <= 32'd0;
            state_q <= NORMAL;
        end else if (exc_valid) begin
            if_pc   <= exc_target;
            tgt_q   <= 32'd0;
            state_q <= NORMAL;
        end else begin
            case (state_q)
                NORMAL: begin
                    if (id_branch_taken) begin
                        if (id_ds_fetched) begin
                            if (if_ready) begin
                                if_pc <= id_branch_target;
                            end else begin
                                tgt_q   <= id_branch_target;
                                state_q <= HOLD;
                            end
                        end else begin
                            // Delay slot still to be fetched: step to it first.
                            tgt_q   <= id_branch_target;
                            state_q <= WAIT_DS;
                            if (if_ready) begin
                                if_pc <= seq_pc;
                            end
                        end
                    end else if (if_ready) begin
                        if_pc <= seq_pc;
                    end
                end
                WAIT_DS, HOLD: begin
                    if (if_ready) begin
                        if_pc   <= tgt_q;
                        state_q <= NORMAL;
                    end
                end
                default: begin
                    state_q <= NORMAL;
                end
            endcase
        end
    end

    // The kill must land in the same cycle the redirect is accepted.
    assign flush_if = resetn &&
                      (exc_valid ||
                       (branch_now && id_ds_fetched && if_ready) ||
                       ((state_q == HOLD) && if_ready));

    assign redirect_pending = (state_q != NORMAL);
    assign state_dbg        = state_q;
    assign tgt_dbg          = tgt_q;

`ifdef PC_ALIGN_CHECK_EN
    assign pc_adel = (if_pc[1:0] != 2'b00);
`else
    assign pc_adel = 1'b0;
`endif

endmodule

// File: tb/tb_pc_redirect.sv
// Directed bench for pc_redirect: reset, branch/delay-slot, hold, exception, wrap, alignment.
module tb_pc_redirect;

    logic        clk;
    logic        resetn;
    logic        id_branch_taken;
    logic [31:0] id_branch_target;
    logic        id_ds_fetched;
    logic        exc_valid;
    logic [31:0] exc_target;
    logic        if_ready;
    logic [31:0] if_pc;
    logic        flush_if;
    logic        redirect_pending;
    logic        pc_adel;
    logic [1:0]  state_dbg;
    logic [31:0] tgt_dbg;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

`ifdef PC_ALIGN_CHECK_EN
    localparam logic ADEL_ON = 1'b1;
`else
    localparam logic ADEL_ON = 1'b0;
`endif

    pc_redirect dut (
        .clk              (clk),
        .resetn           (resetn),
        .id_branch_taken  (id_branch_taken),
        .id_branch_target (id_branch_target),
        .id_ds_fetched    (id_ds_fetched),
        .exc_valid        (exc_valid),
        .exc_target       (exc_target),
        .if_ready         (if_ready),
        .if_pc            (if_pc),
        .flush_if         (flush_if),
        .redirect_pending (redirect_pending),
        .pc_adel          (pc_adel),
        .state_dbg        (state_dbg),
        .tgt_dbg          (tgt_dbg)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        id_branch_taken  = 1'b0;
        id_branch_target = 32'd0;
        id_ds_fetched    = 1'b0;
        exc_valid        = 1'b0;
        exc_target       = 32'd0;
        if_ready         = 1'b0;
    endtask

    task automatic load_pc(input logic [31:0] addr);
        drive_idle();
        exc_valid  = 1'b1;
        exc_target = addr;
        step();
        exc_valid  = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        resetn = 1'b0;
        #1;
        total++; if (if_pc !== 32'hBFC00000) begin bad++; $display("FAIL reset_pc got=%h exp=%h", if_pc, 32'hBFC00000); end
        total++; if (redirect_pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b exp=0", redirect_pending); end
        total++; if (flush_if !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", flush_if); end
        total++; if (tgt_dbg !== 32'd0) begin bad++; $display("FAIL reset_tgt got=%h exp=0", tgt_dbg); end
        step();
        step();
        resetn   = 1'b1;
        if_ready = 1'b1;
        exp_q.push_back(32'hBFC00000);
        exp_q.push_back(32'hBFC00008);
        exp_q.push_back(32'hBFC00010);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            total++; if (if_pc !== e) begin bad++; $display("FAIL reset_seq[%0d] got=%h exp=%h", i, if_pc, e); end
            step();
        end
    endtask

    task automatic test_branch_ds_fetched();
        load_pc(32'h1000);
        total++; if (if_pc !== 32'h1000) begin bad++; $display("FAIL bds_load got=%h exp=1000", if_pc); end
        id_branch_taken  = 1'b1;
        id_branch_target = 32'h2000;
        id_ds_fetched    = 1'b1;
        if_ready         = 1'b1;
        #1;
        total++; if (flush_if !== 1'b1) begin bad++; $display("FAIL bds_flush got=%b exp=1", flush_if); end
        step();
        drive_idle();
        #1;
        total++; if (if_pc !== 32'h2000) begin bad++; $display("FAIL bds_pc got=%h exp=2000", if_pc); end
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL bds_state got=%0d exp=0", state_dbg); end
        total++; if (flush_if !== 1'b0) begin bad++; $display("FAIL bds_flush_once got=%b exp=0", flush_if); end
    endtask

    task automatic test_wait_ds();
        load_pc(32'h1000);
        id_branch_taken  = 1'b1;
        id_branch_target = 32'h3000;
        id_ds_fetched    = 1'b0;
        if_ready         = 1'b1;
        #1;
        total++; if (flush_if !== 1'b0) begin bad++; $display("FAIL wds_noflush got=%b exp=0", flush_if); end
        step();
        total++; if (if_pc !== 32'h1008) begin bad++; $display("FAIL wds_ds_pc got=%h exp=1008", if_pc); end
        total++; if (redirect_pending !== 1'b1) begin bad++; $display("FAIL wds_pending got=%b exp=1", redirect_pending); end
        total++; if (state_dbg !== 2'd1) begin bad++; $display("FAIL wds_state got=%0d exp=1", state_dbg); end
        // a new taken branch while waiting must be ignored
        id_branch_target = 32'h5000;
        id_ds_fetched    = 1'b1;
        if_ready         = 1'b0;
        step();
        drive_idle();
        step();
        total++; if (if_pc !== 32'h1008) begin bad++; $display("FAIL wds_hold_pc got=%h exp=1008", if_pc); end
        total++; if (tgt_dbg !== 32'h3000) begin bad++; $display("FAIL wds_tgt got=%h exp=3000", tgt_dbg); end
        if_ready = 1'b1;
        #1;
        total++; if (flush_if !== 1'b0) begin bad++; $display("FAIL wds_exit_flush got=%b exp=0", flush_if); end
        step();
        total++; if (if_pc !== 32'h3000) begin bad++; $display("FAIL wds_target got=%h exp=3000", if_pc); end
        total++; if (redirect_pending !== 1'b0) begin bad++; $display("FAIL wds_done got=%b exp=0", redirect_pending); end
    endtask

    task automatic test_hold_release();
        load_pc(32'h1000);
        id_branch_taken  = 1'b1;
        id_branch_target = 32'h4000;
        id_ds_fetched    = 1'b1;
        if_ready         = 1'b0;
        step();
        drive_idle();
        total++; if (if_pc !== 32'h1000) begin bad++; $display("FAIL hold_pc got=%h exp=1000", if_pc); end
        total++; if (state_dbg !== 2'd2) begin bad++; $display("FAIL hold_state got=%0d exp=2", state_dbg); end
        if_ready = 1'b1;
        #1;
        total++; if (flush_if !== 1'b1) begin bad++; $display("FAIL hold_flush got=%b exp=1", flush_if); end
        step();
        total++; if (if_pc !== 32'h4000) begin bad++; $display("FAIL hold_target got=%h exp=4000", if_pc); end
        total++; if (redirect_pending !== 1'b0) begin bad++; $display("FAIL hold_done got=%b exp=0", redirect_pending); end
    endtask

    task automatic test_hold_exception();
        load_pc(32'h1000);
        id_branch_taken  = 1'b1;
        id_branch_target = 32'h4000;
        id_ds_fetched    = 1'b1;
        if_ready         = 1'b0;
        step();
        drive_idle();
        exc_valid  = 1'b1;
        exc_target = 32'hBFC00380;
        #1;
        total++; if (flush_if !== 1'b1) begin bad++; $display("FAIL hexc_flush got=%b exp=1", flush_if); end
        step();
        drive_idle();
        total++; if (if_pc !== 32'hBFC00380) begin bad++; $display("FAIL hexc_pc got=%h exp=BFC00380", if_pc); end
        total++; if (tgt_dbg !== 32'd0) begin bad++; $display("FAIL hexc_tgt got=%h exp=0", tgt_dbg); end
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL hexc_state got=%0d exp=0", state_dbg); end
        if_ready = 1'b1;
        step();
        total++; if (if_pc !== 32'hBFC00388) begin bad++; $display("FAIL hexc_next got=%h exp=BFC00388", if_pc); end
    endtask

    task automatic test_no_ready();
        load_pc(32'h6000);
        step();
        step();
        total++; if (if_pc !== 32'h6000) begin bad++; $display("FAIL noready_hold got=%h exp=6000", if_pc); end
    endtask

    task automatic test_wrap();
        load_pc(32'hFFFFFFF8);
        if_ready = 1'b1;
        step();
        total++; if (if_pc !== 32'h00000000) begin bad++; $display("FAIL wrap got=%h exp=0", if_pc); end
        load_pc(32'h1004);
        if_ready = 1'b1;
        step();
        total++; if (if_pc !== 32'h1008) begin bad++; $display("FAIL align_step got=%h exp=1008", if_pc); end
    endtask

    task automatic test_misaligned();
        load_pc(32'h1000);
        total++; if (pc_adel !== 1'b0) begin bad++; $display("FAIL adel_clear got=%b exp=0", pc_adel); end
        id_branch_taken  = 1'b1;
        id_branch_target = 32'h2002;
        id_ds_fetched    = 1'b1;
        if_ready         = 1'b1;
        step();
        drive_idle();
        total++; if (if_pc !== 32'h2002) begin bad++; $display("FAIL adel_pc got=%h exp=2002", if_pc); end
        total++; if (pc_adel !== ADEL_ON) begin bad++; $display("FAIL adel_flag got=%b exp=%b", pc_adel, ADEL_ON); end
        if_ready = 1'b1;
        step();
        total++; if (if_pc !== 32'h2008) begin bad++; $display("FAIL adel_next got=%h exp=2008", if_pc); end
    endtask

    task automatic test_async_reset();
        load_pc(32'h1000);
        id_branch_taken  = 1'b1;
        id_branch_target = 32'h3000;
        id_ds_fetched    = 1'b0;
        if_ready         = 1'b1;
        step();
        drive_idle();
        total++; if (state_dbg !== 2'd1) begin bad++; $display("FAIL areset_pre got=%0d exp=1", state_dbg); end
        #2;
        resetn = 1'b0;
        #1;
        total++; if (if_pc !== 32'hBFC00000) begin bad++; $display("FAIL areset_pc got=%h exp=BFC00000", if_pc); end
        total++; if (redirect_pending !== 1'b0) begin bad++; $display("FAIL areset_pending got=%b exp=0", redirect_pending); end
        step();
        resetn   = 1'b1;
        if_ready = 1'b1;
        step();
        total++; if (if_pc !== 32'hBFC00008) begin bad++; $display("FAIL areset_after got=%h exp=BFC00008", if_pc); end
        total++; if (tgt_dbg !== 32'd0) begin bad++; $display("FAIL areset_tgt got=%h exp=0", tgt_dbg); end
    endtask

    initial begin
        resetn = 1'b0;
        drive_idle();
        step();
        test_reset();
        test_branch_ds_fetched();
        test_wait_ds();
        test_hold_release();
        test_hold_exception();
        test_no_ready();
        test_wrap();
        test_misaligned();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
